// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count, position width, FSM encodings, direction codes.
// Latency: none (package of constants plus one pure function).
// Backpressure: n/a.
package elevator_pkg;

  localparam int FLOORS = 4;   // must equal 2**POS_W
  localparam int POS_W  = 2;   // width of the mover position bus

  // Controller FSM encoding (2 bits)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVING = 2'd1;
  localparam logic [1:0] ST_DOOR   = 2'd2;

  // head encoding on the mover bus
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // SCAN direction choice: keep going while there is work ahead, reverse only when
  // the only remaining work is behind, otherwise leave the direction alone.
  function automatic logic scan_head(input logic cur,
                                     input logic any_above,
                                     input logic any_below);
    logic ahead;
    logic behind;
    ahead  = (cur == DIR_UP) ? any_above : any_below;
    behind = (cur == DIR_UP) ? any_below : any_above;
    if (ahead || !behind) begin
      return cur;
    end
    return (cur == DIR_UP) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Controller <-> mover bus: commands (stop/head/DoorClose) one way, position/Door back.
// Latency: none (wires only).
// Backpressure: none; the mover samples commands on its own slow tick.
//  master (controller): drives stop, head, DoorClose; reads position, Door
//  slave  (mover)     : reads stop, head, DoorClose; drives position, Door
interface elevator_ctrl_if;
  import elevator_pkg::*;

  logic             stop;       // 1 = hold car, door open
  logic             head;       // 1 = up, 0 = down
  logic             DoorClose;  // 1 = close door and travel
  logic [POS_W-1:0] position;   // current floor
  logic             Door;       // 1 = door open

  modport master (
    output stop, head, DoorClose,
    input  position, Door
  );

  modport slave (
    input  stop, head, DoorClose,
    output position, Door
  );

endinterface

// File: rtl/elevator_ctrl_call_register.sv
// Latched floor calls with set/clear and above/below reductions relative to the car.
// Latency: one cycle from call_set/call_clr to pending; reductions are combinational on pending.
// Backpressure: none; the caller decides set/clear priority by how it builds call_clr.
//  clk_1hz, rst (sync active-low) | call_set, call_clr : FLOORS-bit masks
//  position : current floor        | pending, any_above, any_below, here : status
module elevator_ctrl_call_register
  import elevator_pkg::*;
(
  input  logic              clk_1hz,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_set,
  input  logic [FLOORS-1:0] call_clr,
  input  logic [POS_W-1:0]  position,
  output logic [FLOORS-1:0] pending,
  output logic              any_above,
  output logic              any_below,
  output logic              here
);

  logic [FLOORS-1:0] pend_q;

  // Clear is applied after set, so a bit present in call_clr always ends up 0.
  always_ff @(posedge clk_1hz) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q | call_set) & ~call_clr;
    end
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend_q[i] && (POS_W'(i) > position)) any_above = 1'b1;
      if (pend_q[i] && (POS_W'(i) < position)) any_below = 1'b1;
    end
  end

  assign here    = pend_q[position];
  assign pending = pend_q;

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator scheduler commanding one car mover; latches calls and sequences stops.
// Latency: all outputs registered; one cycle from an observed input to the output change.
// Backpressure: none; dwell only counts once the mover reports Door=1.
//  clk_1hz, rst (sync active-low) | call[FLOORS], close_btn : passenger inputs
//  pending[FLOORS] : unserved calls | mv (master) : stop/head/DoorClose out, position/Door in
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int DWELL_CYC = 8
) (
  input  logic              clk_1hz,
  input  logic              rst,
  input  logic [FLOORS-1:0] call,
  input  logic              close_btn,
  output logic [FLOORS-1:0] pending,
  elevator_ctrl_if.master   mv
);

  localparam int DW = $clog2(DWELL_CYC + 1);

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              stop_q, stop_d;
  logic              head_q, head_d;
  logic              dc_q, dc_d;

  logic [FLOORS-1:0] call_clr;
  logic [FLOORS-1:0] here_mask;
  logic              any_above, any_below, here;
  logic              others;
  logic              ahead;
  logic              restart;
  logic              dwell_done;

  elevator_ctrl_call_register u_call_register (
    .clk_1hz   (clk_1hz),
    .rst       (rst),
    .call_set  (call),
    .call_clr  (call_clr),
    .position  (mv.position),
    .pending   (pending),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  assign here_mask = FLOORS'(1) << mv.position;
  // Work somewhere other than the current floor; only this justifies leaving.
  assign others    = any_above | any_below;
  assign ahead     = (head_q == DIR_UP) ? any_above : any_below;
  // A call for the floor being served re-opens the dwell window.
  assign restart   = call[mv.position] | here;
  assign dwell_done = mv.Door && (close_btn || (dwell_q == DW'(DWELL_CYC - 1)));

  // State and output registers
  always_ff @(posedge clk_1hz) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      stop_q  <= 1'b0;
      head_q  <= DIR_UP;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      stop_q  <= stop_d;
      head_q  <= head_d;
      dc_q    <= dc_d;
    end
  end

  // Next state and dwell counter
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        dwell_d = '0;
        if (here)        state_d = ST_DOOR;
        else if (others) state_d = ST_MOVING;
      end
      ST_MOVING: begin
        dwell_d = '0;
        if (here)         state_d = ST_DOOR;
        else if (!others) state_d = ST_IDLE;
      end
      ST_DOOR: begin
        if (restart) begin
          dwell_d = '0;
        end else if (dwell_done) begin
          dwell_d = '0;
          state_d = others ? ST_MOVING : ST_IDLE;
        end else if (mv.Door) begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dwell_d = '0;
      end
    endcase
  end

  // Registered outputs follow the next state; head is re-chosen only when a trip
  // starts or the work ahead has vanished, so it is held for the whole trip.
  always_comb begin
    stop_d   = (state_d == ST_DOOR);
    dc_d     = (state_d == ST_MOVING);
    head_d   = head_q;
    call_clr = '0;
    if ((state_d == ST_MOVING) && ((state_q != ST_MOVING) || !ahead)) begin
      head_d = scan_head(head_q, any_above, any_below);
    end
    if (state_q == ST_DOOR) begin
      call_clr = here_mask;            // serving this floor: clear beats a new call
    end else if (here) begin
      call_clr = here_mask & ~call;    // not yet serving: a fresh call keeps the bit
    end
  end

  assign mv.stop      = stop_q;
  assign mv.head      = head_q;
  assign mv.DoorClose = dc_q;

endmodule
